// File: rtl/layer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// layer_seq_ctrl
//
// Sequences one fully-connected layer of neurons. An upstream vector of
// numInputs words is broadcast to every neuron, one word per cycle. Each
// neuron's activation is then captured once. Finally the activations are
// serialised downstream, neuron 0 first.
//
// FSM: IDLE -> FEED -> WAIT -> DRAIN -> IDLE
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-low
//   in_data       in   upstream activation word
//   in_valid      in   upstream word valid
//   in_ready      out  word accepted when in_valid & in_ready
//   myinput       out  broadcast word to all neurons
//   myinputValid  out  broadcast valid, one pulse per accepted word
//   neuron_out    in   neuron n at [n*dataWidth +: dataWidth]
//   neuron_valid  in   per-neuron output valid
//   out_data      out  serialised activation
//   out_valid     out  output word valid
//   out_ready     in   downstream accept
//   busy          out  high whenever the FSM is not in IDLE
//   layer_done    out  one-cycle pulse after the last output word is taken
//   err           out  sticky error: WAIT timeout, or a neuron_valid pulse
//                      outside WAIT; cleared only by rst
//
// Optional feature (macro LAYER_CTRL_ARGMAX_EN)
//   argmax_idx    out  index of the largest signed word drained; lowest
//                      index wins a tie
//   argmax_valid  out  pulses together with layer_done
// ---------------------------------------------------------------------------
module layer_seq_ctrl #(
    parameter int numInputs   = 784,
    parameter int numNeurons  = 30,
    parameter int dataWidth   = 16,
    parameter int waitTimeout = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [dataWidth-1:0]             in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [dataWidth-1:0]             myinput,
    output logic                             myinputValid,
    input  logic [numNeurons*dataWidth-1:0]  neuron_out,
    input  logic [numNeurons-1:0]            neuron_valid,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             layer_done,
    output logic                             err
`ifdef LAYER_CTRL_ARGMAX_EN
    ,
    output logic [$clog2(numNeurons)-1:0]    argmax_idx,
    output logic                             argmax_valid
`endif
);

    localparam int IN_W  = $clog2(numInputs + 1);
    localparam int OUT_W = $clog2(numNeurons + 1);
    localparam int WT_W  = $clog2(waitTimeout + 1);

    localparam logic [IN_W-1:0]  IN_LAST   = IN_W'(numInputs - 1);
    localparam logic [OUT_W-1:0] OUT_LAST  = OUT_W'(numNeurons - 1);
    localparam logic [WT_W-1:0]  WAIT_LAST = WT_W'(waitTimeout - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                                 state_q, state_d;
    logic [IN_W-1:0]                        in_cnt_q, in_cnt_d;
    logic [WT_W-1:0]                        wait_cnt_q, wait_cnt_d;
    logic [OUT_W-1:0]                       out_idx_q, out_idx_d;
    logic [numNeurons-1:0]                  cap_q, cap_d;
    logic [numNeurons-1:0][dataWidth-1:0]   cap_val_q, cap_val_d;
    logic                                   err_q, err_d;

    logic                                   in_ready_q, in_ready_d;
    logic [dataWidth-1:0]                   myinput_q, myinput_d;
    logic                                   myinput_valid_q, myinput_valid_d;
    logic [dataWidth-1:0]                   out_data_q, out_data_d;
    logic                                   out_valid_q, out_valid_d;
    logic                                   busy_q, busy_d;
    logic                                   layer_done_q, layer_done_d;

    logic                                   accept_s;
    logic                                   out_fire_s;

    // Next-state, counters, capture registers and next values of all outputs.
    always_comb begin
        state_d         = state_q;
        in_cnt_d        = in_cnt_q;
        wait_cnt_d      = wait_cnt_q;
        out_idx_d       = out_idx_q;
        cap_d           = cap_q;
        cap_val_d       = cap_val_q;
        err_d           = err_q;
        layer_done_d    = 1'b0;
        accept_s        = 1'b0;
        out_fire_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The word that wakes us is only consumed once in_ready is up.
                if (in_valid) begin
                    state_d = S_FEED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FEED: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d = '0;
                        state_d  = S_WAIT;
                    end else begin
                        in_cnt_d = in_cnt_q + IN_W'(1);
                    end
                end else begin
                    in_cnt_d = in_cnt_q;
                end
            end
            S_WAIT: begin
                // First pulse per neuron wins; repeats are dropped silently.
                for (int n = 0; n < numNeurons; n++) begin
                    if (neuron_valid[n] && !cap_q[n]) begin
                        cap_d[n]     = 1'b1;
                        cap_val_d[n] = neuron_out[n*dataWidth +: dataWidth];
                    end else begin
                        cap_d[n]     = cap_q[n];
                    end
                end
                if (&cap_d) begin
                    wait_cnt_d = '0;
                    state_d    = S_DRAIN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Missing neurons drain as the zero left in their slot.
                    wait_cnt_d = '0;
                    err_d      = 1'b1;
                    state_d    = S_DRAIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + WT_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    out_fire_s = 1'b1;
                    if (out_idx_q == OUT_LAST) begin
                        out_idx_d    = '0;
                        cap_d        = '0;
                        cap_val_d    = '0;
                        layer_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        out_idx_d = out_idx_q + OUT_W'(1);
                    end
                end else begin
                    out_idx_d = out_idx_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A neuron answering outside WAIT means the layers are out of step.
        if ((state_q != S_WAIT) && (|neuron_valid)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end

        // Outputs are registered from next-state so they line up with state_q.
        in_ready_d      = (state_d == S_FEED);
        busy_d          = (state_d != S_IDLE);
        out_valid_d     = (state_d == S_DRAIN);
        myinput_valid_d = accept_s;
        if (accept_s) begin
            myinput_d = in_data;
        end else begin
            myinput_d = myinput_q;
        end
        if (state_d == S_DRAIN) begin
            out_data_d = cap_val_d[out_idx_d];
        end else begin
            out_data_d = '0;
        end
    end

    // State, counters, capture store and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            in_cnt_q        <= '0;
            wait_cnt_q      <= '0;
            out_idx_q       <= '0;
            cap_q           <= '0;
            cap_val_q       <= '0;
            err_q           <= 1'b0;
            in_ready_q      <= 1'b0;
            myinput_q       <= '0;
            myinput_valid_q <= 1'b0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            layer_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            in_cnt_q        <= in_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            out_idx_q       <= out_idx_d;
            cap_q           <= cap_d;
            cap_val_q       <= cap_val_d;
            err_q           <= err_d;
            in_ready_q      <= in_ready_d;
            myinput_q       <= myinput_d;
            myinput_valid_q <= myinput_valid_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            busy_q          <= busy_d;
            layer_done_q    <= layer_done_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign myinput      = myinput_q;
    assign myinputValid = myinput_valid_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign layer_done   = layer_done_q;
    assign err          = err_q;

`ifdef LAYER_CTRL_ARGMAX_EN
    localparam int AMX_W = $clog2(numNeurons);

    logic signed [dataWidth-1:0] amx_max_q, amx_max_d;
    logic [AMX_W-1:0]            amx_idx_q, amx_idx_d;
    logic [AMX_W-1:0]            argmax_idx_q, argmax_idx_d;
    logic                        argmax_valid_q, argmax_valid_d;
    logic                        better_s;

    // Running signed maximum over accepted words; out_data_q is the word in flight.
    always_comb begin
        amx_max_d      = amx_max_q;
        amx_idx_d      = amx_idx_q;
        argmax_idx_d   = argmax_idx_q;
        argmax_valid_d = 1'b0;
        // Strict compare keeps the lower index on ties; word 0 always seeds.
        better_s = (out_idx_q == '0) || ($signed(out_data_q) > amx_max_q);
        if (out_fire_s) begin
            if (better_s) begin
                amx_max_d = $signed(out_data_q);
                amx_idx_d = AMX_W'(out_idx_q);
            end else begin
                amx_max_d = amx_max_q;
            end
            if (layer_done_d) begin
                argmax_idx_d   = amx_idx_d;
                argmax_valid_d = 1'b1;
            end else begin
                argmax_valid_d = 1'b0;
            end
        end else begin
            amx_max_d = amx_max_q;
        end
    end

    // Argmax tracking registers and result hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            amx_max_q      <= '0;
            amx_idx_q      <= '0;
            argmax_idx_q   <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            amx_max_q      <= amx_max_d;
            amx_idx_q      <= amx_idx_d;
            argmax_idx_q   <= argmax_idx_d;
            argmax_valid_q <= argmax_valid_d;
        end
    end

    assign argmax_idx   = argmax_idx_q;
    assign argmax_valid = argmax_valid_q;
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_layer_seq_ctrl
//
// Directed bench for layer_seq_ctrl with numInputs=4, numNeurons=3,
// dataWidth=16, waitTimeout=8. Broadcast words and drained activations are
// checked through scoreboard queues filled when stimulus is driven.
// Inputs change 1 ns after the rising edge; monitors sample on the falling edge.
// With LAYER_CTRL_ARGMAX_EN defined the argmax outputs are covered as well.
// ---------------------------------------------------------------------------
module tb_layer_seq_ctrl;

    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int WT = 8;

    logic              clk;
    logic              rst;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     myinput;
    logic              myinputValid;
    logic [NN*DW-1:0]  neuron_out;
    logic [NN-1:0]     neuron_valid;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              layer_done;
    logic              err;
`ifdef LAYER_CTRL_ARGMAX_EN
    logic [$clog2(NN)-1:0] argmax_idx;
    logic                  argmax_valid;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int ld_cnt  = 0;
    logic prev_ld = 1'b0;

    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_q[$];

    // Bench model of the capture store for the current layer.
    logic [NN-1:0] m_cap;
    logic [DW-1:0] m_val[NN];

    layer_seq_ctrl #(
        .numInputs   (NI),
        .numNeurons  (NN),
        .dataWidth   (DW),
        .waitTimeout (WT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .myinput      (myinput),
        .myinputValid (myinputValid),
        .neuron_out   (neuron_out),
        .neuron_valid (neuron_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .layer_done   (layer_done),
        .err          (err)
`ifdef LAYER_CTRL_ARGMAX_EN
        ,
        .argmax_idx   (argmax_idx),
        .argmax_valid (argmax_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Broadcast scoreboard: every myinputValid pulse must match the next fed word.
    always @(negedge clk) begin
        if (rst && myinputValid) begin
            logic [31:0] e;
            e = (in_q.size() > 0) ? 32'(in_q.pop_front()) : 32'hFFFF_FFFF;
            check("myinput", 32'(myinput), e);
        end
    end

    // Output scoreboard: every accepted word must match the next expected activation.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            logic [31:0] e;
            e = (out_q.size() > 0) ? 32'(out_q.pop_front()) : 32'hFFFF_FFFF;
            check("out_data", 32'(out_data), e);
        end
    end

    // layer_done must be a single-cycle pulse; count pulses for the stimulus.
    always @(negedge clk) begin
        if (layer_done) begin
            ld_cnt++;
            check("layer_done_pulse", 32'(prev_ld), 32'd0);
        end
`ifdef LAYER_CTRL_ARGMAX_EN
        if (layer_done || argmax_valid) begin
            check("argmax_valid_with_done", 32'(argmax_valid), 32'(layer_done));
        end
`endif
        prev_ld = layer_done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_layer();
        m_cap = '0;
        for (int n = 0; n < NN; n++) m_val[n] = '0;
    endtask

    task automatic feed(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                        input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        logic [DW-1:0] w[NI];
        int cnt;
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < NI; i++) begin
            in_data  = w[i];
            in_valid = 1'b1;
            in_q.push_back(w[i]);
            cnt = 0;
            while (!in_ready && cnt < 20) begin
                tick();
                cnt++;
            end
            check("feed_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("feed_done_in_ready", 32'(in_ready), 32'd0);
        check("feed_done_busy", 32'(busy), 32'd1);
    endtask

    task automatic pulse(input logic [NN-1:0] v, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] c);
        logic [DW-1:0] vals[NN];
        vals = '{a, b, c};
        neuron_out   = {c, b, a};
        neuron_valid = v;
        for (int n = 0; n < NN; n++) begin
            if (v[n] && !m_cap[n]) begin
                m_cap[n] = 1'b1;
                m_val[n] = vals[n];
            end
        end
        tick();
        neuron_valid = '0;
        neuron_out   = '0;
    endtask

    task automatic drain(input bit bp);
        int cnt;
        int start;
        start = ld_cnt;
        for (int n = 0; n < NN; n++) out_q.push_back(m_val[n]);
        if (bp) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_out_data", 32'(out_data), 32'(m_val[1]));
                tick();
            end
        end
        out_ready = 1'b1;
        cnt = 0;
        while (ld_cnt == start && cnt < 50) begin
            tick();
            cnt++;
        end
        out_ready = 1'b0;
        check("layer_done_count", 32'(ld_cnt), 32'(start + 1));
        check("drain_out_q_empty", 32'(out_q.size()), 32'd0);
        check("drain_in_q_empty", 32'(in_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        neuron_out   = '0;
        neuron_valid = '0;
        out_ready    = 1'b0;
        new_layer();
        tick();
        tick();

        // Reset values
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_myinputValid", 32'(myinputValid), 32'd0);
        check("rst_myinput", 32'(myinput), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_layer_done", 32'(layer_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();

        // Basic: all neurons answer together
        new_layer();
        feed(16'd1, 16'd2, 16'd3, 16'd4);
        pulse(3'b111, 16'h0010, 16'h0020, 16'h0030);
        drain(1'b0);
        check("basic_err", 32'(err), 32'd0);

        // Staggered with a duplicate pulse on neuron 0
        new_layer();
        feed(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        pulse(3'b001, 16'h0011, 16'h0000, 16'h0000);
        check("stag_busy", 32'(busy), 32'd1);
        check("stag_out_valid", 32'(out_valid), 32'd0);
        pulse(3'b101, 16'h0099, 16'h0000, 16'h0033);
        check("stag_still_waiting", 32'(out_valid), 32'd0);
        pulse(3'b010, 16'h0000, 16'h0022, 16'h0000);
        drain(1'b0);
        check("stag_err", 32'(err), 32'd0);

        // Backpressure in DRAIN
        new_layer();
        feed(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        pulse(3'b111, 16'h00A1, 16'h00A2, 16'h00A3);
        drain(1'b1);
        check("bp_err", 32'(err), 32'd0);

        // Timeout: only neuron 1 answers
        new_layer();
        feed(16'h0005, 16'h0006, 16'h0007, 16'h0008);
        pulse(3'b010, 16'h0000, 16'h0055, 16'h0000);
        repeat (6) tick();
        check("to_err_before", 32'(err), 32'd0);
        check("to_out_valid_before", 32'(out_valid), 32'd0);
        tick();
        check("to_err_after", 32'(err), 32'd1);
        check("to_out_valid_after", 32'(out_valid), 32'd1);
        drain(1'b0);

        // Error stays set into the next vector
        new_layer();
        feed(16'h0009, 16'h000A, 16'h000B, 16'h000C);
        check("sticky_err_feed", 32'(err), 32'd1);
        pulse(3'b111, 16'h0E01, 16'h0E02, 16'h0E03);
        drain(1'b0);
        check("sticky_err_end", 32'(err), 32'd1);

        // Reset in the middle of FEED
        in_data  = 16'h0007;
        in_valid = 1'b1;
        in_q.push_back(16'h0007);
        tick();
        tick();
        in_data = 16'h0008;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_myinputValid", 32'(myinputValid), 32'd0);
        check("mid_rst_in_q_empty", 32'(in_q.size()), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        new_layer();
        feed(16'd1, 16'd2, 16'd3, 16'd4);
        pulse(3'b111, 16'h0070, 16'h0080, 16'h0090);
        drain(1'b0);
        check("fresh_err", 32'(err), 32'd0);

`ifdef LAYER_CTRL_ARGMAX_EN
        // Argmax: tie between 0 and 2 keeps 0
        new_layer();
        feed(16'd1, 16'd2, 16'd3, 16'd4);
        pulse(3'b111, 16'h0100, 16'hFF00, 16'h0100);
        drain(1'b0);
        check("argmax_tie", 32'(argmax_idx), 32'd0);
        // Argmax: 0x8000 is negative, largest is index 1
        new_layer();
        feed(16'd5, 16'd6, 16'd7, 16'd8);
        pulse(3'b111, 16'h0005, 16'h7000, 16'h8000);
        drain(1'b0);
        check("argmax_signed", 32'(argmax_idx), 32'd1);
        repeat (3) tick();
        check("argmax_hold", 32'(argmax_idx), 32'd1);
`endif

        // neuron_valid while IDLE is an error
        neuron_valid = 3'b001;
        tick();
        neuron_valid = '0;
        tick();
        check("idle_nv_err", 32'(err), 32'd1);
        check("idle_nv_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
